// File: rtl/alu_cond_stage.sv
// alu_cond_stage: condition-evaluation stage behind the 32-bit ALU.
// Each accepted op has its condition code tested against the NZCV status
// register. A failing op is squashed. A passing op updates the status
// register if its S bit is set, and its result is queued in a 2-entry skid
// buffer that feeds register-file writeback.
//
// Optional feature: define ALU_SQUASH_CNT_EN to add the saturating 16-bit
// squash_cnt output, which counts squashed ops.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       upstream handshake (in_ready is registered)
//   in_result, in_flags     ALU result and flags {C,Z,N,V} (bit3..bit0)
//   in_cond, in_set_flags   condition code and S bit
//   in_rd                   destination register index
//   out_valid/out_ready     writeback handshake
//   out_result, out_rd      head buffer entry
//   status_q                architectural status register, same order as in_flags
//   squash_cnt              squashed-op counter (ALU_SQUASH_CNT_EN only)
module alu_cond_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [3:0]        in_flags,
   input  logic [3:0]        in_cond,
   input  logic              in_set_flags,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic [3:0]        status_q
`ifdef ALU_SQUASH_CNT_EN
   ,
   output logic [15:0]       squash_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e state_q, state_d;

   logic              accept;
   logic              cond_pass;
   logic              push;
   logic              pop;
   logic              head_load;
   logic              head_from_slot;
   logic              slot_load;
   logic [DATA_W-1:0] slot_result;
   logic [RD_W-1:0]   slot_rd;

   // Status bit aliases.
   logic flag_v, flag_n, flag_z, flag_c;
   assign flag_v = status_q[0];
   assign flag_n = status_q[1];
   assign flag_z = status_q[2];
   assign flag_c = status_q[3];

   // Condition evaluation against the status register before this op's update.
   always_comb begin
      cond_pass = 1'b0;
      case (in_cond)
         4'd0:    cond_pass = flag_z;
         4'd1:    cond_pass = !flag_z;
         4'd2:    cond_pass = flag_c;
         4'd3:    cond_pass = !flag_c;
         4'd4:    cond_pass = flag_n;
         4'd5:    cond_pass = !flag_n;
         4'd6:    cond_pass = flag_v;
         4'd7:    cond_pass = !flag_v;
         4'd8:    cond_pass = flag_c && !flag_z;
         4'd9:    cond_pass = !flag_c || flag_z;
         4'd10:   cond_pass = (flag_n == flag_v);
         4'd11:   cond_pass = (flag_n != flag_v);
         4'd12:   cond_pass = !flag_z && (flag_n == flag_v);
         4'd13:   cond_pass = flag_z || (flag_n != flag_v);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign push   = accept && cond_pass;
   assign pop    = out_valid && out_ready;

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Next occupancy and buffer load controls.
   always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
      head_from_slot = 1'b0;
      slot_load      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d   = ONE;
               head_load = 1'b1;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_d   = FULL;
               slot_load = 1'b1;
            end else if (push && pop) begin
               head_load = 1'b1;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so no push can coincide with the pop.
            if (pop) begin
               state_d        = ONE;
               head_load      = 1'b1;
               head_from_slot = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Handshake outputs registered from the next occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         out_valid <= (state_d != EMPTY);
         in_ready  <= (state_d != FULL);
      end
   end

   // Head entry drives the outputs directly and holds when the buffer is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result <= '0;
         out_rd     <= '0;
      end else if (head_load) begin
         out_result <= head_from_slot ? slot_result : in_result;
         out_rd     <= head_from_slot ? slot_rd     : in_rd;
      end
   end

   // Second entry, used only while FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_result <= '0;
         slot_rd     <= '0;
      end else if (slot_load) begin
         slot_result <= in_result;
         slot_rd     <= in_rd;
      end
   end

   // Status register: written only by passing flag-setting ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     status_q <= 4'h0;
      else if (push && in_set_flags)  status_q <= in_flags;
   end

`ifdef ALU_SQUASH_CNT_EN
   // Saturating count of squashed ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         squash_cnt <= 16'h0000;
      else if (accept && !cond_pass && (squash_cnt != 16'hFFFF))
         squash_cnt <= squash_cnt + 16'(1);
   end
`endif

endmodule

// File: tb/tb_alu_cond_stage.sv
// Self-checking bench for alu_cond_stage: directed scenarios plus a random
// run, checked against a queue-based reference model.
module tb_alu_cond_stage;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RD_W   = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic [3:0]        in_flags;
   logic [3:0]        in_cond;
   logic              in_set_flags;
   logic [RD_W-1:0]   in_rd;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [RD_W-1:0]   out_rd;
   logic [3:0]        status_q;
`ifdef ALU_SQUASH_CNT_EN
   logic [15:0]       squash_cnt;
`endif

   alu_cond_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_flags     (in_flags),
      .in_cond      (in_cond),
      .in_set_flags (in_set_flags),
      .in_rd        (in_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_rd       (out_rd),
      .status_q     (status_q)
`ifdef ALU_SQUASH_CNT_EN
      ,
      .squash_cnt   (squash_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] res;
      logic [RD_W-1:0]   rd;
   } ent_t;

   // Reference model state.
   ent_t              mq[$];
   logic [3:0]        m_status;
   logic [15:0]       m_sq;
   logic [DATA_W-1:0] m_last_res;
   logic [RD_W-1:0]   m_last_rd;

   int n_tests = 0;
   int n_fail  = 0;

   // Condition table written from the architectural definitions.
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] st);
      bit v, n, z, cf;
      v = st[0]; n = st[1]; z = st[2]; cf = st[3];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cf;
         4'd3:  return !cf;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cf && !z;
         4'd9:  return !cf || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_status   = 4'h0;
      m_sq       = 16'h0;
      m_last_res = '0;
      m_last_rd  = '0;
   endfunction

   // Advance the model by one edge using the current inputs, then clock.
   task automatic step();
      bit acc, pass, pop;
      pop  = (mq.size() > 0) && out_ready;
      acc  = in_valid && (mq.size() < 2);
      pass = acc && cond_ok(in_cond, m_status);
      if (pop) void'(mq.pop_front());
      if (pass) begin
         mq.push_back({in_result, in_rd});
         if (in_set_flags) m_status = in_flags;
      end
      if (acc && !pass && m_sq != 16'hFFFF) m_sq = m_sq + 16'd1;
      if (mq.size() > 0) begin
         m_last_res = mq[0].res;
         m_last_rd  = mq[0].rd;
      end
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic s,
                        input logic [3:0] f, input logic [RD_W-1:0] rd,
                        input logic [DATA_W-1:0] r);
      in_valid = v; in_cond = c; in_set_flags = s; in_flags = f; in_rd = rd; in_result = r;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; out_ready = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_tests++; if (status_q !== 4'h0) begin n_fail++; $display("FAIL reset_status got %h exp 0", status_q); end
      n_tests++; if (out_result !== '0 || out_rd !== '0) begin n_fail++; $display("FAIL reset_out_data got %h/%h exp 0/0", out_result, out_rd); end
`ifdef ALU_SQUASH_CNT_EN
      n_tests++; if (squash_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_squash_cnt got %h exp 0", squash_cnt); end
`endif
   endtask

   task automatic test_flag_chain();
      out_ready = 1'b1;
      drive(1'b1, 4'd14, 1'b1, 4'b0100, 4'd3, 32'h0);
      step();
      n_tests++; if (out_valid !== 1'b1 || out_rd !== 4'd3 || out_result !== 32'h0) begin n_fail++; $display("FAIL chain_op1 got v=%b rd=%0d res=%h exp v=1 rd=3 res=0", out_valid, out_rd, out_result); end
      n_tests++; if (status_q !== 4'b0100) begin n_fail++; $display("FAIL chain_status got %b exp 0100", status_q); end
      drive(1'b1, 4'd0, 1'b0, 4'b0000, 4'd5, 32'hDEAD);
      step();
      n_tests++; if (out_valid !== 1'b1 || out_rd !== 4'd5 || out_result !== 32'hDEAD) begin n_fail++; $display("FAIL chain_op2 got v=%b rd=%0d res=%h exp v=1 rd=5 res=dead", out_valid, out_rd, out_result); end
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      step();
      n_tests++; if (out_valid !== 1'b0 || out_rd !== 4'd5) begin n_fail++; $display("FAIL chain_drain got v=%b rd=%0d exp v=0 rd=5", out_valid, out_rd); end
      n_tests++; if (status_q !== 4'b0100) begin n_fail++; $display("FAIL chain_status_end got %b exp 0100", status_q); end
   endtask

   task automatic test_squash();
      logic [15:0] sq_before;
      sq_before = m_sq;
      out_ready = 1'b1;
      drive(1'b1, 4'd1, 1'b1, 4'b1000, 4'd7, 32'h1234);
      step();
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL squash_out_valid got %b exp 0", out_valid); end
      n_tests++; if (status_q !== 4'b0100) begin n_fail++; $display("FAIL squash_status got %b exp 0100", status_q); end
`ifdef ALU_SQUASH_CNT_EN
      n_tests++; if (squash_cnt !== sq_before + 16'd1) begin n_fail++; $display("FAIL squash_cnt got %0d exp %0d", squash_cnt, sq_before + 16'd1); end
`endif
   endtask

   task automatic test_signed();
      out_ready = 1'b1;
      drive(1'b1, 4'd14, 1'b1, 4'b0010, 4'd1, 32'h1);      // N=1 V=0
      step();
      drive(1'b1, 4'd10, 1'b0, 4'h0, 4'd9, 32'h9);         // GE fails
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ge_n1v0 got v=%b exp 0", out_valid); end
      drive(1'b1, 4'd11, 1'b0, 4'h0, 4'd10, 32'hA);        // LT passes
      step();
      n_tests++; if (out_valid !== 1'b1 || out_rd !== 4'd10) begin n_fail++; $display("FAIL lt_n1v0 got v=%b rd=%0d exp v=1 rd=10", out_valid, out_rd); end
      drive(1'b1, 4'd14, 1'b1, 4'b0011, 4'd2, 32'h2);      // N=1 V=1 Z=0
      step();
      drive(1'b1, 4'd12, 1'b0, 4'h0, 4'd11, 32'hB);        // GT passes
      step();
      n_tests++; if (out_valid !== 1'b1 || out_rd !== 4'd11) begin n_fail++; $display("FAIL gt_n1v1 got v=%b rd=%0d exp v=1 rd=11", out_valid, out_rd); end
      drive(1'b1, 4'd15, 1'b1, 4'hF, 4'd12, 32'hC);        // NV never
      step();
      n_tests++; if (out_valid !== 1'b0 || status_q !== 4'b0011) begin n_fail++; $display("FAIL nv got v=%b st=%b exp v=0 st=0011", out_valid, status_q); end
      drive(1'b1, 4'd14, 1'b1, 4'b1100, 4'd3, 32'h3);      // C=1 Z=1
      step();
      drive(1'b1, 4'd8, 1'b0, 4'h0, 4'd13, 32'hD);         // HI fails
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hi_c1z1 got v=%b exp 0", out_valid); end
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 4'd14, 1'b0, 4'h0, 4'd1, 32'hA1);
      step();
      drive(1'b1, 4'd14, 1'b0, 4'h0, 4'd2, 32'hA2);
      step();
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
      drive(1'b1, 4'd14, 1'b0, 4'h0, 4'd3, 32'hA3);
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++; if (out_rd !== 4'd1 || out_result !== 32'hA1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall_head got v=%b rd=%0d res=%h rdy=%b exp v=1 rd=1 res=a1 rdy=0", out_valid, out_rd, out_result, in_ready);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_tests++; if (out_rd !== 4'd2 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop got rd=%0d rdy=%b exp rd=2 rdy=1", out_rd, in_ready); end
      step();
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      n_tests++; if (in_ready !== 1'b0 || out_rd !== 4'd2) begin n_fail++; $display("FAIL bp_third_accept got rdy=%b rd=%0d exp rdy=0 rd=2", in_ready, out_rd); end
      out_ready = 1'b1;
      step();
      n_tests++; if (out_rd !== 4'd3 || out_result !== 32'hA3) begin n_fail++; $display("FAIL bp_order got rd=%0d res=%h exp rd=3 res=a3", out_rd, out_result); end
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      drive(1'b1, 4'd14, 1'b0, 4'h0, 4'd0, 32'h100);
      step();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 4'd14, 1'b0, 4'h0, RD_W'(i), 32'h100 + 32'(i));
         step();
         n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_rd !== RD_W'(i) || out_result !== 32'h100 + 32'(i)) begin
            n_fail++; $display("FAIL b2b_%0d got v=%b rdy=%b rd=%0d res=%h exp v=1 rdy=1 rd=%0d res=%h", i, out_valid, in_ready, out_rd, out_result, i, 32'h100 + 32'(i));
         end
      end
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom),
               4'($urandom), RD_W'($urandom), 32'($urandom));
         out_ready = ($urandom_range(0, 2) != 0);
         step();
         n_tests++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
            n_fail++; $display("FAIL rand_hs cyc%0d got v=%b rdy=%b exp v=%b rdy=%b", i, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
         end
         n_tests++; if (out_result !== m_last_res || out_rd !== m_last_rd) begin
            n_fail++; $display("FAIL rand_data cyc%0d got %h/%0d exp %h/%0d", i, out_result, out_rd, m_last_res, m_last_rd);
         end
         n_tests++; if (status_q !== m_status) begin
            n_fail++; $display("FAIL rand_status cyc%0d got %b exp %b", i, status_q, m_status);
         end
`ifdef ALU_SQUASH_CNT_EN
         n_tests++; if (squash_cnt !== m_sq) begin
            n_fail++; $display("FAIL rand_squash cyc%0d got %0d exp %0d", i, squash_cnt, m_sq);
         end
`endif
      end
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      out_ready = 1'b1;
      step(); step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 4'd14, 1'b1, 4'b1111, 4'd6, 32'hE1);
      step();
      drive(1'b1, 4'd14, 1'b0, 4'h0, 4'd7, 32'hE2);
      step();
      n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid); end
      drive(1'b0, 4'd0, 1'b0, 4'h0, '0, '0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++; if (out_valid !== 1'b0 || status_q !== 4'h0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_async got v=%b st=%b rdy=%b exp v=0 st=0000 rdy=1", out_valid, status_q, in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_stale got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_flag_chain();
      test_squash();
      test_signed();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
